// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle of the memory-stage controller.
// master: main control FSM; slave: mem_access_ctrl.
interface mem_access_ctrl_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] rdata;

    modport master (
        output req, op, addr, wdata,
        input  busy, done, misalign, rdata
    );

    modport slave (
        input  req, op, addr, wdata,
        output busy, done, misalign, rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: accepts one load/store, checks alignment, drives
// the data memory for one ACCESS cycle and returns an extended load result.
module mem_access_ctrl #(
    parameter int DM_AW = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_ctrl_if.slave     bus,
    output logic [DM_AW-1:0]     dm_addr,
    output logic [3:0]           dm_be,
    output logic [31:0]          dm_din,
    output logic                 dm_we,
    input  logic [31:0]          dm_dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [DM_AW+1:0]   addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               req_misaligned;
    logic               op_is_store;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_value;

    // Address bits above the data-memory window are not needed.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:DM_AW+2];

    // Alignment check on the incoming request.
    always_comb begin
        req_misaligned = 1'b0;
        case (bus.op)
            OP_LW, OP_SW:         req_misaligned = (bus.addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: req_misaligned = bus.addr[0];
            default:              req_misaligned = 1'b0;
        endcase
    end

    // Lane selection and extension of the memory read word.
    always_comb begin
        op_is_store = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);
        case (addr_q[1:0])
            2'd0:    ld_byte = dm_dout[7:0];
            2'd1:    ld_byte = dm_dout[15:8];
            2'd2:    ld_byte = dm_dout[23:16];
            default: ld_byte = dm_dout[31:24];
        endcase
        ld_half = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (op_q)
            OP_LW:   ld_value = dm_dout;
            OP_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_value = {16'h0000, ld_half};
            OP_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_value = {24'h000000, ld_byte};
            default: ld_value = rdata_q;
        endcase
    end

    // Next-state logic and request latching.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (req_misaligned) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ACCESS;
                        op_d    = op_t'(bus.op);
                        addr_d  = bus.addr[DM_AW+1:0];
                        wdata_d = bus.wdata;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                if (!op_is_store) begin
                    rdata_d = ld_value;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the current state and latched request.
    always_comb begin
        bus.busy     = (state_q == S_ACCESS);
        bus.done     = (state_q == S_DONE) || (state_q == S_ERR);
        bus.misalign = (state_q == S_ERR);
        bus.rdata    = rdata_q;
        dm_addr      = addr_q[DM_AW+1:2];
        dm_din       = wdata_q;
        dm_we        = (state_q == S_ACCESS) && op_is_store;
        dm_be        = '0;
        if (dm_we) begin
            case (op_q)
                OP_SW:   dm_be = 4'b1111;
                OP_SH:   dm_be = addr_q[1] ? 4'b1100 : 4'b0011;
                OP_SB:   dm_be = 4'b0001 << addr_q[1:0];
                default: dm_be = '0;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-enable data memory model.
module tb_mem_access_ctrl;

    localparam int DM_AW = 10;

    logic             clk;
    logic             rst;
    logic [DM_AW-1:0] dm_addr;
    logic [3:0]       dm_be;
    logic [31:0]      dm_din;
    logic             dm_we;
    logic [31:0]      dm_dout;
    logic             mem_init;
    logic [31:0]      mem [0:(1<<DM_AW)-1];

    int checks;
    int failures;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.DM_AW(DM_AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .dm_addr (dm_addr),
        .dm_be   (dm_be),
        .dm_din  (dm_din),
        .dm_we   (dm_we),
        .dm_dout (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, negedge write, lane data from low bits.
    assign dm_dout = mem[dm_addr];
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << DM_AW); i++) mem[i] = 32'h0;
            mem[4] = 32'h8091A2B3;
        end else if (dm_we) begin
            case (dm_be)
                4'b1111: mem[dm_addr] = dm_din;
                4'b0011: mem[dm_addr][15:0]  = dm_din[15:0];
                4'b1100: mem[dm_addr][31:16] = dm_din[15:0];
                4'b0001: mem[dm_addr][7:0]   = dm_din[7:0];
                4'b0010: mem[dm_addr][15:8]  = dm_din[7:0];
                4'b0100: mem[dm_addr][23:16] = dm_din[7:0];
                4'b1000: mem[dm_addr][31:24] = dm_din[7:0];
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one request from posedge+1; return at posedge+1 the cycle after done.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] w, input logic exp_mis,
                          input logic [3:0] exp_be, input int exp_we);
        int lat;
        int we_cnt;
        logic [3:0]       cap_be;
        logic [31:0]      cap_din;
        logic [DM_AW-1:0] cap_addr;
        cap_be = '0; cap_din = '0; cap_addr = '0;
        bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = w;
        @(posedge clk); #1;
        bus.req = 1'b0;
        lat = 1;
        we_cnt = 0;
        while (!bus.done && lat < 10) begin
            if (dm_we) begin
                we_cnt++;
                cap_be = dm_be; cap_din = dm_din; cap_addr = dm_addr;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_mis ? 1 : 2);
        check({tag, ".misalign"}, {31'b0, bus.misalign}, {31'b0, exp_mis});
        check({tag, ".we_cycles"}, we_cnt, exp_we);
        if (exp_we > 0) begin
            check({tag, ".be"}, {28'b0, cap_be}, {28'b0, exp_be});
            check({tag, ".din"}, cap_din, w);
            check({tag, ".dm_addr"}, {22'b0, cap_addr}, {22'b0, a[DM_AW+1:2]});
        end
        @(posedge clk); #1;
        check({tag, ".done_drop"}, {30'b0, bus.done, bus.misalign}, 32'h0);
    endtask

    int n_busy;
    int n_done;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; mem_init = 1'b1;
        bus.req = 1'b0; bus.op = 3'b000; bus.addr = '0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy",     {31'b0, bus.busy}, 32'h0);
        check("reset.done",     {31'b0, bus.done}, 32'h0);
        check("reset.misalign", {31'b0, bus.misalign}, 32'h0);
        check("reset.rdata",    bus.rdata, 32'h0);
        check("reset.dm_addr",  {22'b0, dm_addr}, 32'h0);
        check("reset.dm_be",    {28'b0, dm_be}, 32'h0);
        check("reset.dm_din",   dm_din, 32'h0);
        check("reset.dm_we",    {31'b0, dm_we}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        mem_init = 1'b0;
        @(posedge clk); #1;

        // Loads from the preloaded word 0x8091A2B3
        run_op("lw10",  3'b000, 32'h10, 32'h0, 1'b0, 4'h0, 0); check("lw10.rdata",  bus.rdata, 32'h8091A2B3);
        run_op("lb13",  3'b011, 32'h13, 32'h0, 1'b0, 4'h0, 0); check("lb13.rdata",  bus.rdata, 32'hFFFFFF80);
        run_op("lbu13", 3'b100, 32'h13, 32'h0, 1'b0, 4'h0, 0); check("lbu13.rdata", bus.rdata, 32'h00000080);
        run_op("lh12",  3'b001, 32'h12, 32'h0, 1'b0, 4'h0, 0); check("lh12.rdata",  bus.rdata, 32'hFFFF8091);
        run_op("lhu10", 3'b010, 32'h10, 32'h0, 1'b0, 4'h0, 0); check("lhu10.rdata", bus.rdata, 32'h0000A2B3);
        run_op("lb11",  3'b011, 32'h11, 32'h0, 1'b0, 4'h0, 0); check("lb11.rdata",  bus.rdata, 32'hFFFFFFA2);

        // Stores, each followed by a word read-back; stores leave rdata alone
        run_op("sb11", 3'b111, 32'h11, 32'h000000CC, 1'b0, 4'b0010, 1);
        check("sb11.rdata_hold", bus.rdata, 32'hFFFFFFA2);
        run_op("lw_a", 3'b000, 32'h10, 32'h0, 1'b0, 4'h0, 0); check("lw_a.rdata", bus.rdata, 32'h8091CCB3);
        run_op("sh12", 3'b110, 32'h12, 32'h00001234, 1'b0, 4'b1100, 1);
        run_op("lw_b", 3'b000, 32'h10, 32'h0, 1'b0, 4'h0, 0); check("lw_b.rdata", bus.rdata, 32'h1234CCB3);
        run_op("sh10", 3'b110, 32'h10, 32'h00005678, 1'b0, 4'b0011, 1);
        run_op("lw_c", 3'b000, 32'h10, 32'h0, 1'b0, 4'h0, 0); check("lw_c.rdata", bus.rdata, 32'h12345678);
        run_op("sw10", 3'b101, 32'h10, 32'hDEADBEEF, 1'b0, 4'b1111, 1);
        run_op("lw_d", 3'b000, 32'h10, 32'h0, 1'b0, 4'h0, 0); check("lw_d.rdata", bus.rdata, 32'hDEADBEEF);
        run_op("sb13", 3'b111, 32'h13, 32'h00000011, 1'b0, 4'b1000, 1);
        run_op("lw_e", 3'b000, 32'h10, 32'h0, 1'b0, 4'h0, 0); check("lw_e.rdata", bus.rdata, 32'h11ADBEEF);

        // Misaligned requests are rejected without touching memory or rdata
        run_op("lw11", 3'b000, 32'h11, 32'h0,        1'b1, 4'h0, 0); check("lw11.rdata", bus.rdata, 32'h11ADBEEF);
        run_op("sh13", 3'b110, 32'h13, 32'hFFFFFFFF, 1'b1, 4'h0, 0); check("sh13.rdata", bus.rdata, 32'h11ADBEEF);
        run_op("sw12", 3'b101, 32'h12, 32'hFFFFFFFF, 1'b1, 4'h0, 0); check("sw12.rdata", bus.rdata, 32'h11ADBEEF);
        run_op("lbu12", 3'b100, 32'h12, 32'h0, 1'b0, 4'h0, 0); check("lbu12.rdata", bus.rdata, 32'h000000AD);

        // Reset during a load ACCESS: back to IDLE, rdata cleared, no done
        bus.req = 1'b1; bus.op = 3'b000; bus.addr = 32'h10;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("rst_ld.busy_before", {31'b0, bus.busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_ld.busy",    {31'b0, bus.busy}, 32'h0);
        check("rst_ld.done",    {31'b0, bus.done}, 32'h0);
        check("rst_ld.rdata",   bus.rdata, 32'h0);
        check("rst_ld.dm_addr", {22'b0, dm_addr}, 32'h0);
        @(posedge clk); #1;
        check("rst_ld.no_done", {31'b0, bus.done}, 32'h0);

        // Reset during a store ACCESS: the negedge write still lands
        bus.req = 1'b1; bus.op = 3'b101; bus.addr = 32'h20; bus.wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        bus.req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_st.dm_we", {31'b0, dm_we}, 32'h0);
        check("rst_st.done",  {31'b0, bus.done}, 32'h0);
        @(posedge clk); #1;
        run_op("lw20", 3'b000, 32'h20, 32'h0, 1'b0, 4'h0, 0); check("lw20.rdata", bus.rdata, 32'h55AA55AA);

        // req held through ACCESS and DONE: exactly one access
        n_busy = 0; n_done = 0;
        bus.req = 1'b1; bus.op = 3'b000; bus.addr = 32'h10;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 2) bus.req = 1'b0;
            if (bus.busy) n_busy++;
            if (bus.done) n_done++;
        end
        check("held.busy_cycles", n_busy, 1);
        check("held.done_pulses", n_done, 1);
        check("held.rdata", bus.rdata, 32'h11ADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage controller of the multicycle CPU; sits directly upstream of the 4 KB data memory (dm_4k).
- Accepts one load/store request from the main control FSM and checks alignment.
- Generates the data memory's word address, byte enables and write strobe.
- For loads, captures the memory read word, selects the addressed byte/halfword, sign/zero-extends it and holds the result for register write-back.

Parameters:
- DM_AW, 10, data-memory word-address width; dm_addr = addr[DM_AW+1:2].

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  start request; sampled only in IDLE.
- op  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data (rt value).
- busy  output  1  high in ACCESS.
- done  output  1  one-cycle completion pulse.
- misalign  output  1  high together with done when the request was rejected.
- rdata  output  32  extended load result; held until the next completed load.
- dm_addr  output  DM_AW  word address to data memory.
- dm_be  output  4  byte enables to data memory.
- dm_din  output  32  write data to data memory.
- dm_we  output  1  write enable to data memory.
- dm_dout  input  32  combinational read word from data memory.

Behaviour:
- Interface (already decided): one clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; busy=0, done=0, misalign=0, rdata=0, dm_addr=0, dm_be=0, dm_din=0, dm_we=0.
- States: IDLE, ACCESS, DONE, ERR.
- IDLE, req=1, aligned: latch op, addr, wdata; go to ACCESS.
- IDLE, req=1, misaligned: go to ERR. Misaligned means lw/sw with addr[1:0]!=0, or lh/lhu/sh with addr[0]!=0. Byte ops are never misaligned.
- ACCESS (1 cycle): busy=1; dm_addr = latched addr[DM_AW+1:2].
  - Store: dm_we=1 for exactly this cycle. Memory commits on the negedge inside this cycle.
  - Load: dm_we=0; rdata is loaded from dm_dout at the closing posedge.
  - Next state: DONE.
- DONE: done=1 for one cycle; next state IDLE.
- ERR: done=1 and misalign=1 for one cycle; no dm_we; rdata unchanged; next state IDLE.
- Latency: req sampled at edge N; done high during cycle N+2 (aligned) or cycle N+1 (misaligned). A new req is accepted no earlier than the cycle after done.
- req outside IDLE is ignored; a request is not queued.
- Byte enables (driven only while dm_we=1, else 4'b0000):
  - sw: 1111.
  - sh: addr[1]=0 gives 0011; addr[1]=1 gives 1100.
  - sb: addr[1:0] 00/01/10/11 gives 0001/0010/0100/1000.
- dm_din = latched wdata, unshifted. The memory takes lane data from din[15:0] for halfwords and din[7:0] for bytes.
- Load extraction:
  - lb/lbu: byte dm_dout[8*a+7:8*a], where a = addr[1:0].
  - lh/lhu: halfword dm_dout[31:16] if addr[1]=1, else dm_dout[15:0].
  - lw: full word.
  - lb/lh sign-extend to 32 bits; lbu/lhu zero-extend.
- Stores leave rdata unchanged.
- Reset mid-operation: rst returns to IDLE at the next posedge with all outputs at reset values; no done pulse.
  - A store whose ACCESS cycle has started still commits, because the memory writes on the negedge before the reset edge.
- misalign is cleared in every state except ERR.

Test Plan:
- Preload word 0x10 = 0x8091A2B3; lw 0x10 -> done 2 cycles after req, rdata=0x8091A2B3, dm_we never 1.
- lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lh 0x12 -> 0xFFFF8091; lhu 0x10 -> 0x0000A2B3; lb 0x11 -> 0xFFFFFFA2.
- sb 0x11, wdata=0x000000CC -> dm_be=0010, dm_din=0x000000CC, dm_we high exactly 1 cycle, dm_addr=4; then lw 0x10 -> 0x8091CCB3.
- sh 0x12, wdata=0x00001234 -> dm_be=1100; lw 0x10 -> 0x1234CCB3; sw 0x10, wdata=0xDEADBEEF; lw -> 0xDEADBEEF.
- lw 0x11, sh 0x13, sw 0x12 -> each gives done=misalign=1 one cycle after req, dm_we=0, rdata unchanged; next aligned request completes normally.
- rst during ACCESS of lw 0x10 -> IDLE next cycle, rdata=0, no done. req held high while busy -> only one access performed.
